// File: rtl/if_fetch_pkg.sv
// Shared CPU constants: instruction encodings, bus widths and pipeline-wide values
// used by the fetch stage and its neighbours.
package if_fetch_pkg;
   localparam int CPU_ADDR_W = 30;
   localparam int CPU_DATA_W = 32;

   // addi x0, x0, 0 -- canonical no-op placed in empty pipeline slots
   localparam logic [CPU_DATA_W-1:0] ISA_NOP = 32'h0000_0013;

   localparam int PIPE_STAGES   = 5;
   localparam int BRANCH_DELAY  = 1;
endpackage

// File: rtl/if_fetch_pc_sel.sv
// Next-PC mux: flush restart, taken branch, pending branch, then sequential increment.
// Kept standalone so a predictor can later feed it without touching the fetch FSM.
module if_pc_sel #(
   parameter int ADDR_W = 30
) (
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_addr,
   input  logic              br_pend,
   input  logic [ADDR_W-1:0] br_pend_addr,
   input  logic [ADDR_W-1:0] pc,
   output logic [ADDR_W-1:0] next_pc
);
   always_comb begin
      next_pc = pc + ADDR_W'(1);
      if (flush)
         next_pc = new_pc;
      else if (br_taken)
         next_pc = br_addr;
      else if (br_pend)
         next_pc = br_pend_addr;
   end
endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC register, single-master read handshake, stall hold
// buffer, pending delayed-branch capture and the IF/ID pipeline register.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter int               ADDR_W   = CPU_ADDR_W,
   parameter int               DATA_W   = CPU_DATA_W,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              flush,
   input  logic [ADDR_W-1:0] new_pc,
   input  logic              br_taken,
   input  logic [ADDR_W-1:0] br_addr,
   output logic              bus_req,
   output logic [ADDR_W-1:0] bus_addr,
   input  logic              bus_rdy,
   input  logic [DATA_W-1:0] bus_rd_data,
   output logic [ADDR_W-1:0] if_pc,
   output logic [DATA_W-1:0] if_insn,
   output logic              if_en,
   output logic              busy
);
   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;
   localparam logic [DATA_W-1:0] NOP = DATA_W'(ISA_NOP);

   logic [0:0]        state_reg;
   logic [ADDR_W-1:0] pc_reg;
   logic [ADDR_W-1:0] hold_pc_reg;
   logic [DATA_W-1:0] hold_insn_reg;
   logic              br_pend_reg;
   logic [ADDR_W-1:0] br_pend_addr_reg;
   logic [ADDR_W-1:0] if_pc_reg;
   logic [DATA_W-1:0] if_insn_reg;
   logic              if_en_reg;

   logic              br_taken_eff;
   logic [ADDR_W-1:0] pc_next;

   // A stalled ID stage did not really resolve the branch it is showing.
   assign br_taken_eff = br_taken & ~stall;

   if_pc_sel #(.ADDR_W(ADDR_W)) u_pc_sel (
      .flush        (flush),
      .new_pc       (new_pc),
      .br_taken     (br_taken_eff),
      .br_addr      (br_addr),
      .br_pend      (br_pend_reg),
      .br_pend_addr (br_pend_addr_reg),
      .pc           (pc_reg),
      .next_pc      (pc_next)
   );

   assign bus_req  = (state_reg == ST_FETCH) & ~reset;
   assign bus_addr = pc_reg;
   assign busy     = bus_req & ~bus_rdy;
   assign if_pc    = if_pc_reg;
   assign if_insn  = if_insn_reg;
   assign if_en    = if_en_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg        <= ST_FETCH;
         pc_reg           <= RESET_PC;
         br_pend_reg      <= 1'b0;
         br_pend_addr_reg <= '0;
         hold_pc_reg      <= '0;
         hold_insn_reg    <= NOP;
         if_pc_reg        <= '0;
         if_insn_reg      <= NOP;
         if_en_reg        <= 1'b0;
      end else if (flush) begin
         state_reg   <= ST_FETCH;
         pc_reg      <= pc_next;
         br_pend_reg <= 1'b0;
         if_pc_reg   <= '0;
         if_insn_reg <= NOP;
         if_en_reg   <= 1'b0;
      end else if (state_reg == ST_FETCH) begin
         if (bus_rdy) begin
            if (!stall) begin
               if_pc_reg   <= pc_reg;
               if_insn_reg <= bus_rd_data;
               if_en_reg   <= 1'b1;
               pc_reg      <= pc_next;
               br_pend_reg <= 1'b0;
            end else begin
               // Park the completed word so the stall costs no refetch.
               hold_pc_reg   <= pc_reg;
               hold_insn_reg <= bus_rd_data;
               state_reg     <= ST_HOLD;
            end
         end else if (!stall) begin
            if_insn_reg <= NOP;
            if_en_reg   <= 1'b0;
            if (br_taken_eff) begin
               br_pend_reg      <= 1'b1;
               br_pend_addr_reg <= br_addr;
            end
         end
      end else if (!stall) begin
         if_pc_reg   <= hold_pc_reg;
         if_insn_reg <= hold_insn_reg;
         if_en_reg   <= 1'b1;
         pc_reg      <= pc_next;
         br_pend_reg <= 1'b0;
         state_reg   <= ST_FETCH;
      end
   end
endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: reset stream, wait states, stall hold, delayed and
// pending branches, flush priority and PC wrap-around.
module tb_if_fetch;
   import if_fetch_pkg::*;

   localparam int ADDR_W = 30;
   localparam int DATA_W = 32;

   logic              clk = 1'b0;
   logic              reset, stall, flush, br_taken, bus_rdy;
   logic [ADDR_W-1:0] new_pc, br_addr;
   logic              bus_req, if_en, busy;
   logic [ADDR_W-1:0] bus_addr, if_pc;
   logic [DATA_W-1:0] bus_rd_data, if_insn;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Memory image: each word tags its own address with 2'b10 in the top bits.
   assign bus_rd_data = {2'b10, bus_addr};

   if_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(30'h100)) dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
      .br_taken(br_taken), .br_addr(br_addr), .bus_req(bus_req), .bus_addr(bus_addr),
      .bus_rdy(bus_rdy), .bus_rd_data(bus_rd_data), .if_pc(if_pc), .if_insn(if_insn),
      .if_en(if_en), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [ADDR_W-1:0] pc_e, input logic en_e);
      chk({tag, ".if_en"}, 64'(if_en), 64'(en_e));
      if (en_e) begin
         chk({tag, ".if_pc"}, 64'(if_pc), 64'(pc_e));
         chk({tag, ".if_insn"}, 64'(if_insn), 64'({2'b10, pc_e}));
      end
   endtask

   task automatic do_flush(input logic [ADDR_W-1:0] addr);
      flush = 1'b1; new_pc = addr; bus_rdy = 1'b0; br_taken = 1'b0; stall = 1'b0;
      cyc();
      flush = 1'b0;
   endtask

   initial begin
      reset = 1'b1; stall = 1'b0; flush = 1'b0; br_taken = 1'b0; bus_rdy = 1'b1;
      new_pc = '0; br_addr = '0;
      cyc(); cyc();
      chk("rst.if_en", 64'(if_en), 64'(0));
      chk("rst.if_insn", 64'(if_insn), 64'(ISA_NOP));
      chk("rst.if_pc", 64'(if_pc), 64'(0));
      chk("rst.bus_req", 64'(bus_req), 64'(0));

      // Zero-wait stream from RESET_PC
      reset = 1'b0; settle();
      chk("zw.bus_req", 64'(bus_req), 64'(1));
      chk("zw.addr0", 64'(bus_addr), 64'(30'h100));
      cyc();
      chk_ifid("zw.i0", 30'h100, 1'b1);
      chk("zw.addr1", 64'(bus_addr), 64'(30'h101));
      cyc();
      chk_ifid("zw.i1", 30'h101, 1'b1);
      chk("zw.addr2", 64'(bus_addr), 64'(30'h102));
      cyc();
      chk_ifid("zw.i2", 30'h102, 1'b1);

      // Two wait states at 0x10
      do_flush(30'h10);
      chk("ws.flush_en", 64'(if_en), 64'(0));
      chk("ws.addr", 64'(bus_addr), 64'(30'h10));
      bus_rdy = 1'b0; settle();
      chk("ws.busy0", 64'(busy), 64'(1));
      cyc();
      chk_ifid("ws.bubble0", 30'h0, 1'b0);
      chk("ws.busy1", 64'(busy), 64'(1));
      cyc();
      chk_ifid("ws.bubble1", 30'h0, 1'b0);
      bus_rdy = 1'b1; settle();
      chk("ws.busy2", 64'(busy), 64'(0));
      cyc();
      chk_ifid("ws.data", 30'h10, 1'b1);
      chk("ws.next_addr", 64'(bus_addr), 64'(30'h11));

      // Stall on completion at 0x20, three stalled cycles; br_taken must be ignored
      do_flush(30'h20);
      bus_rdy = 1'b1; stall = 1'b1; br_taken = 1'b1; br_addr = 30'h999;
      cyc();
      chk("st.req0", 64'(bus_req), 64'(0));
      chk("st.en0", 64'(if_en), 64'(0));
      cyc();
      chk("st.req1", 64'(bus_req), 64'(0));
      cyc();
      chk("st.req2", 64'(bus_req), 64'(0));
      chk("st.en2", 64'(if_en), 64'(0));
      stall = 1'b0; br_taken = 1'b0;
      cyc();
      chk_ifid("st.release", 30'h20, 1'b1);
      chk("st.req3", 64'(bus_req), 64'(1));
      chk("st.addr", 64'(bus_addr), 64'(30'h21));
      cyc();
      chk_ifid("st.next", 30'h21, 1'b1);

      // Delayed branch resolved while fetching 0x31
      do_flush(30'h31);
      bus_rdy = 1'b1; br_taken = 1'b1; br_addr = 30'h400; settle();
      chk("db.addr", 64'(bus_addr), 64'(30'h31));
      cyc();
      chk_ifid("db.slot", 30'h31, 1'b1);
      chk("db.target", 64'(bus_addr), 64'(30'h400));
      br_taken = 1'b0;
      cyc();
      chk_ifid("db.tgt_insn", 30'h400, 1'b1);

      // Branch while the bus waits at 0x50
      do_flush(30'h50);
      bus_rdy = 1'b0; br_taken = 1'b1; br_addr = 30'h600;
      cyc();
      chk("pb.en", 64'(if_en), 64'(0));
      chk("pb.addr", 64'(bus_addr), 64'(30'h50));
      br_taken = 1'b0; bus_rdy = 1'b1;
      cyc();
      chk_ifid("pb.slot", 30'h50, 1'b1);
      chk("pb.target", 64'(bus_addr), 64'(30'h600));
      cyc();
      chk_ifid("pb.tgt_insn", 30'h600, 1'b1);
      chk("pb.seq", 64'(bus_addr), 64'(30'h601));

      // Flush beats a pending branch and a simultaneous br_taken
      do_flush(30'h60);
      bus_rdy = 1'b0; br_taken = 1'b1; br_addr = 30'h700;
      cyc();
      flush = 1'b1; new_pc = 30'h7; br_taken = 1'b1; br_addr = 30'h800; bus_rdy = 1'b1;
      cyc();
      chk("fl.en", 64'(if_en), 64'(0));
      chk("fl.addr", 64'(bus_addr), 64'(30'h7));
      flush = 1'b0; br_taken = 1'b0; bus_rdy = 1'b1;
      cyc();
      chk_ifid("fl.data", 30'h7, 1'b1);
      chk("fl.no_pend", 64'(bus_addr), 64'(30'h8));

      // PC wrap at the top of the address space
      do_flush(30'h3FFF_FFFF);
      bus_rdy = 1'b1;
      cyc();
      chk_ifid("wr.top", 30'h3FFF_FFFF, 1'b1);
      chk("wr.addr", 64'(bus_addr), 64'(30'h0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout bench did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the CPU pipeline. It holds the fetch PC, runs a single-master read handshake on the instruction bus, and drives the IF/ID pipeline register (`if_pc`, `if_insn`, `if_en`) that the decoder and the ID/EX register consume. Two cases cost no instruction: a downstream stall while a fetch completes, and a branch resolved while the bus is still waiting. The stage handles stall, flush (exception/restart) and delayed-branch redirection.

## Interface
- `ADDR_W`, 30: word-address width.
- `DATA_W`, 32: instruction width.
- `RESET_PC`, 0: first fetch word address after reset.

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high; clock `clk`.
- `stall` in 1: downstream stall; IF/ID register holds. Must not depend combinationally on `busy`.
- `flush` in 1: pipeline flush.
- `new_pc` in `ADDR_W`: restart address used with `flush`.
- `br_taken` in 1: ID stage resolved a taken branch.
- `br_addr` in `ADDR_W`: branch target word address.
- `bus_req` out 1: fetch request.
- `bus_addr` out `ADDR_W`: fetch word address (= `pc`).
- `bus_rdy` in 1: read data valid this cycle, completing the request.
- `bus_rd_data` in `DATA_W`: instruction word.
- `if_pc` out `ADDR_W`: PC of the instruction in IF/ID.
- `if_insn` out `DATA_W`: instruction in IF/ID.
- `if_en` out 1: IF/ID entry valid.
- `busy` out 1: fetch outstanding and not completing, i.e. `bus_req & ~bus_rdy`. Goes to the pipeline controller.

## Operation
- **State:**
  - `pc`: next fetch address.
  - FSM: FETCH or HOLD.
  - Hold buffer: `hold_insn`, `hold_pc`.
  - Pending branch: `br_pend`, `br_pend_addr`.
- **`bus_req`** = (state==FETCH) & ~`reset`. `bus_addr` = `pc`. A request may be dropped without `bus_rdy` (flush).
- **Priority each cycle:** `reset` > `flush` > `stall` > normal.
- **Reset:**
  - `pc`=`RESET_PC`, state FETCH, `br_pend`=0.
  - `if_pc`=0, `if_insn`=`ISA_NOP`, `if_en`=0.
  - Hold buffer = 0 / `ISA_NOP`.
- **Flush** (regardless of `stall`, state, `bus_rdy`):
  - `pc`=`new_pc`, state FETCH, `br_pend`=0.
  - IF/ID loaded with 0 / `ISA_NOP` / `if_en`=0.
  - Any in-flight data is discarded.
- **FETCH, `bus_rdy`=1, `stall`=0:**
  - IF/ID loads `pc` / `bus_rd_data` / `if_en`=1.
  - `pc` is updated to the first applicable of: `br_addr` if `br_taken`; else `br_pend_addr` if `br_pend`; else `pc`+1.
  - `br_pend` clears.
- **FETCH, `bus_rdy`=1, `stall`=1:**
  - IF/ID holds.
  - `hold_insn`/`hold_pc` capture the data/`pc`; state → HOLD.
  - `pc` is not updated.
- **FETCH, `bus_rdy`=0, `stall`=0:**
  - Bubble: IF/ID loads `if_en`=0, `if_insn`=`ISA_NOP`, `if_pc` unchanged.
  - If `br_taken`, set `br_pend`=1 and `br_pend_addr`=`br_addr`.
- **FETCH, `bus_rdy`=0, `stall`=1:** nothing changes.
- **HOLD** (`bus_req`=0):
  - While `stall`=1, hold.
  - When `stall`=0: IF/ID loads `hold_pc`/`hold_insn`/`if_en`=1; `pc` is updated by the same branch/pending/+1 rule; state → FETCH.
- **Branch semantics:** delayed branch. The word fetched in the cycle the branch resolves (or the next completing fetch, via `br_pend`) is the delay slot and is issued. The following fetch uses the target.
- **`br_taken` gating:** ignored when `stall`=1 (ID did not advance).
- **Arithmetic:** `pc`+1 wraps modulo 2^`ADDR_W` (max → 0), with no flag.

## Timing
- **Zero-wait bus** (`bus_rdy` in the request cycle): one instruction per cycle; IF/ID valid the cycle after `bus_rdy`.
- **Reset:** first `bus_req` the cycle after `reset` deasserts. The first instruction is in IF/ID one cycle after its `bus_rdy`.
- **N-wait bus:** N bubbles (`if_en`=0) per fetch when unstalled; `busy`=1 for those N cycles.
- **Flush:** the next request at `new_pc` is issued the cycle after `flush`; `if_en`=0 for at least that cycle.
- **Stall during HOLD:** no bus traffic. Release costs no extra cycle: the held word appears the cycle after `stall` falls, and the fetch of the next `pc` starts in that same cycle.
- **Simultaneous `flush` + `bus_rdy`:** data dropped.
- **Simultaneous `flush` + `br_taken`:** flush wins.

## Structure
- A shared CPU package holds the `ISA_NOP` encoding and the address/data widths, together with the existing pipeline constants.
- FSM state encoding is local (1 bit).
- One natural sub-module, `if_pc_sel`: the combinational next-PC mux (flush/branch/pending/increment), reusable for prediction later.
- Everything else stays in `if_fetch`.

## Test plan
- **Reset + zero-wait stream:** `RESET_PC`=0x100, `bus_rdy`=1 always → `bus_addr` 0x100, 0x101, 0x102; `if_pc` follows one cycle later with `if_en`=1.
- **Wait states:** `bus_rdy` low 2 cycles at 0x10 → `busy`=1 for 2 cycles, two `if_en`=0 bubbles, then `if_pc`=0x10 with the correct data.
- **Stall on completion:** `stall`=1 in the `bus_rdy` cycle for `pc` 0x20, held 3 cycles → `bus_req`=0 in HOLD. 0x20 appears the cycle after `stall` falls, then the fetch at 0x21. No instruction is lost or duplicated.
- **Delayed branch:** `br_taken`, `br_addr`=0x400 while fetching 0x31 → 0x31 issued as the delay slot, next `bus_addr`=0x400.
- **Pending branch:** `br_taken` with `bus_rdy`=0 at 0x50 → after the data arrives, 0x50 is issued, then `bus_addr`=`br_pend_addr`.
- **Flush:** `flush` with `new_pc`=0x7 during a wait state and a simultaneous `br_taken` → `if_en`=0, `br_pend` cleared, next `bus_addr`=0x7. Also check `pc`=0x3FFFFFFF wraps to 0.
